// File: rtl/normalizer_pipe_pkg.sv
// normalizer_pipe_pkg: format selector shared by the normalizer and its users.
package normalizer_pipe_pkg;
    typedef enum logic [1:0] {FP32 = 2'd0, FP16X2 = 2'd1} fp_fmt_e;
endpackage

// File: rtl/normalizer_pipe.sv
// normalizer_pipe: pipelined LZC + left-shift normalizer, one FP32 lane or two half-width lanes.
// Level 2^i is followed by a register when PIPE_MASK[i] is set; the output register always exists.
module normalizer_pipe
    import normalizer_pipe_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int CW = $clog2(WIDTH),
    parameter logic [CW-1:0] PIPE_MASK = CW'(4),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_fmt_e          in_fmt,
    input  logic [WIDTH-1:0] in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output fp_fmt_e          out_fmt,
    output logic [WIDTH-1:0] out_r,
    output logic [CW-1:0]    out_cnt_h,
    output logic [CW-1:0]    out_cnt_l,
    output logic             out_zero_h,
    output logic             out_zero_l,
    output logic [TAG_W-1:0] out_tag
);
    localparam int HALF = WIDTH / 2;

    // Occupancy of every stage; unregistered levels count as full so the ready chain skips them.
    logic [CW:0] w_full;
    assign in_ready = out_ready || !(&w_full);

    for (genvar k = 0; k < CW; k++) begin : g_lvl
        localparam int S = 1 << (CW - 1 - k);
        logic             w_iv, w_ov, w_fp, w_hz, w_lz;
        fp_fmt_e          w_ifmt, w_ofmt;
        logic [WIDTH-1:0] w_id, w_nd, w_od;
        logic [HALF-1:0]  w_hi, w_lo;
        logic [CW-1:0]    w_ich, w_icl, w_nch, w_ncl, w_och, w_ocl;
        logic [TAG_W-1:0] w_itag, w_otag;
        if (k == 0) begin : g_src
            assign w_iv   = in_valid;
            assign w_ifmt = in_fmt;
            assign w_id   = in_x;
            assign w_ich  = '0;
            assign w_icl  = '0;
            assign w_itag = in_tag;
        end else begin : g_src
            assign w_iv   = g_lvl[k-1].w_ov;
            assign w_ifmt = g_lvl[k-1].w_ofmt;
            assign w_id   = g_lvl[k-1].w_od;
            assign w_ich  = g_lvl[k-1].w_och;
            assign w_icl  = g_lvl[k-1].w_ocl;
            assign w_itag = g_lvl[k-1].w_otag;
        end
        assign w_fp = (w_ifmt == FP32);
        // The widest level exceeds a half lane, so dual-lane entries bypass it.
        if (k == 0) begin : g_shift
            assign w_hz = w_fp && ~|w_id[WIDTH-1 -: S];
            assign w_lz = 1'b0;
            assign w_hi = w_id[WIDTH-1:HALF];
            assign w_lo = w_id[HALF-1:0];
        end else begin : g_shift
            assign w_hz = ~|w_id[WIDTH-1 -: S];
            assign w_lz = !w_fp && ~|w_id[HALF-1 -: S];
            assign w_hi = w_hz ? w_id[WIDTH-1:HALF] << S : w_id[WIDTH-1:HALF];
            assign w_lo = w_lz ? w_id[HALF-1:0] << S : w_id[HALF-1:0];
        end
        assign w_nd  = w_fp ? (w_hz ? w_id << S : w_id) : {w_hi, w_lo};
        assign w_nch = w_ich | (w_hz ? CW'(S) : '0);
        assign w_ncl = w_icl | (w_lz ? CW'(S) : '0);
        if (PIPE_MASK[CW-1-k]) begin : g_reg
            logic             r_v;
            fp_fmt_e          r_fmt;
            logic [WIDTH-1:0] r_d;
            logic [CW-1:0]    r_ch, r_cl;
            logic [TAG_W-1:0] r_tag;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_fmt <= FP32;
                    r_d   <= '0;
                    r_ch  <= '0;
                    r_cl  <= '0;
                    r_tag <= '0;
                end else if (flush) begin
                    r_v <= 1'b0;
                end else if (out_ready || !(&w_full[CW:k])) begin
                    r_v   <= w_iv;
                    r_fmt <= w_ifmt;
                    r_d   <= w_nd;
                    r_ch  <= w_nch;
                    r_cl  <= w_ncl;
                    r_tag <= w_itag;
                end
            end
            assign w_full[k] = r_v;
            assign w_ov      = r_v;
            assign w_ofmt    = r_fmt;
            assign w_od      = r_d;
            assign w_och     = r_ch;
            assign w_ocl     = r_cl;
            assign w_otag    = r_tag;
        end else begin : g_reg
            assign w_full[k] = 1'b1;
            assign w_ov      = w_iv;
            assign w_ofmt    = w_ifmt;
            assign w_od      = w_nd;
            assign w_och     = w_nch;
            assign w_ocl     = w_ncl;
            assign w_otag    = w_itag;
        end
    end

    logic             w_fp_last;
    logic [WIDTH-1:0] w_d_last;
    assign w_fp_last = (g_lvl[CW-1].w_ofmt == FP32);
    assign w_d_last  = g_lvl[CW-1].w_od;
    assign w_full[CW] = out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_fmt    <= FP32;
            out_r      <= '0;
            out_cnt_h  <= '0;
            out_cnt_l  <= '0;
            out_zero_h <= 1'b0;
            out_zero_l <= 1'b0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_ready || !out_valid) begin
            out_valid  <= g_lvl[CW-1].w_ov;
            out_fmt    <= g_lvl[CW-1].w_ofmt;
            out_r      <= w_d_last;
            out_cnt_h  <= g_lvl[CW-1].w_och;
            out_cnt_l  <= g_lvl[CW-1].w_ocl;
            out_zero_h <= w_fp_last ? ~|w_d_last : ~|w_d_last[WIDTH-1:HALF];
            out_zero_l <= !w_fp_last && ~|w_d_last[HALF-1:0];
            out_tag    <= g_lvl[CW-1].w_otag;
        end
    end
endmodule

// File: tb/tb_normalizer_pipe.sv
// tb_normalizer_pipe: directed and randomized checks of normalizer_pipe against a plain LZC model.
module tb_normalizer_pipe;
    import normalizer_pipe_pkg::*;

    typedef struct packed {
        fp_fmt_e     fmt;
        logic [27:0] r;
        logic [4:0]  ch;
        logic [4:0]  cl;
        logic        zh;
        logic        zl;
        logic [3:0]  tag;
    } res_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    fp_fmt_e     in_fmt = FP32;
    logic [27:0] in_x = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, out_zero_h, out_zero_l;
    fp_fmt_e     out_fmt;
    logic [27:0] out_r;
    logic [4:0]  out_cnt_h, out_cnt_l;
    logic [3:0]  out_tag;
    int          total = 0, bad = 0;
    res_t        got[$], exp_q[$];

    always #5 clk = ~clk;

    normalizer_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_x(in_x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_r(out_r),
        .out_cnt_h(out_cnt_h), .out_cnt_l(out_cnt_l), .out_zero_h(out_zero_h),
        .out_zero_l(out_zero_l), .out_tag(out_tag)
    );

    function automatic res_t cur();
        return '{out_fmt, out_r, out_cnt_h, out_cnt_l, out_zero_h, out_zero_l, out_tag};
    endfunction

    // Reference: count leading zeros per lane directly, then shift by that count.
    function automatic res_t model(fp_fmt_e f, logic [27:0] x, logic [3:0] t);
        res_t        m;
        logic [13:0] h, l;
        int          n;
        m = '0;
        m.fmt = f;
        m.tag = t;
        if (f == FP32) begin
            if (x == 0) begin
                m.ch = 5'd31;
                m.zh = 1'b1;
            end else begin
                n = 0;
                for (int b = 27; b >= 0 && !x[b]; b--) n++;
                m.ch = 5'(n);
                m.r  = x << n;
            end
        end else begin
            h = x[27:14];
            l = x[13:0];
            if (h == 0) begin
                m.ch = 5'd15;
                m.zh = 1'b1;
            end else begin
                n = 0;
                for (int b = 13; b >= 0 && !h[b]; b--) n++;
                m.ch = 5'(n);
                h = h << n;
            end
            if (l == 0) begin
                m.cl = 5'd15;
                m.zl = 1'b1;
            end else begin
                n = 0;
                for (int b = 13; b >= 0 && !l[b]; b--) n++;
                m.cl = 5'(n);
                l = l << n;
            end
            m.r = {h, l};
        end
        return m;
    endfunction

    function automatic logic [27:0] rx(fp_fmt_e f);
        logic [27:0] v;
        if (f == FP32) v = 28'($urandom) >> $urandom_range(0, 28);
        else v = {14'($urandom) >> $urandom_range(0, 14), 14'($urandom) >> $urandom_range(0, 14)};
        return v;
    endfunction

    function automatic fp_fmt_e rfmt();
        return ($urandom_range(0, 1) == 1) ? FP16X2 : FP32;
    endfunction

    // One clock of stimulus; records accepted entries (as model results) and consumed outputs.
    task automatic drive(input logic v, input fp_fmt_e f, input logic [27:0] x, input logic [3:0] t,
                         input logic ordy, output logic acc, output logic con);
        in_valid = v;
        in_fmt = f;
        in_x = x;
        in_tag = t;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        if (con) got.push_back(cur());
        if (acc) exp_q.push_back(model(f, x, t));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t z;
        z = '{FP32, 28'h0, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++;
        if (cur() !== z) begin bad++; $display("FAIL reset_outputs got=%h want=%h", cur(), z); end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        fp_fmt_e     vf[4];
        logic [27:0] vx[4];
        logic [3:0]  vt[4];
        res_t        ve[4];
        logic        a, c;
        int          lat;
        vf[0] = FP32;   vx[0] = 28'h0000001; vt[0] = 4'd3;
        vf[1] = FP16X2; vx[1] = {14'h0001, 14'h0800}; vt[1] = 4'd5;
        vf[2] = FP32;   vx[2] = 28'h0; vt[2] = 4'd6;
        vf[3] = FP16X2; vx[3] = {14'h0000, 14'h0001}; vt[3] = 4'd7;
        ve[0] = '{FP32, 28'h8000000, 5'd27, 5'd0, 1'b0, 1'b0, 4'd3};
        ve[1] = '{FP16X2, 28'h8002000, 5'd13, 5'd2, 1'b0, 1'b0, 4'd5};
        ve[2] = '{FP32, 28'h0, 5'd31, 5'd0, 1'b1, 1'b0, 4'd6};
        ve[3] = '{FP16X2, 28'h0002000, 5'd15, 5'd13, 1'b1, 1'b0, 4'd7};
        for (int i = 0; i < 4; i++) begin
            got.delete();
            exp_q.delete();
            drive(1'b1, vf[i], vx[i], vt[i], 1'b1, a, c);
            lat = 0;
            while (got.size() == 0 && lat < 10) begin
                drive(1'b0, FP32, '0, '0, 1'b1, a, c);
                lat++;
            end
            total++;
            if (lat !== 2) begin bad++; $display("FAIL directed%0d_latency got=%0d want=2", i, lat); end
            total++;
            if (got.size() != 1 || got[0] !== ve[i]) begin
                bad++;
                $display("FAIL directed%0d_result got=%h want=%h", i, (got.size() > 0) ? got[0] : '0, ve[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        fp_fmt_e     fm[6];
        logic [27:0] xs[6];
        res_t        hold;
        logic        a, c, have;
        int          nx;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            fm[i] = rfmt();
            xs[i] = rx(fm[i]);
        end
        nx = 0;
        have = 1'b0;
        hold = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b1, fm[nx], xs[nx], 4'(nx), 1'b0, a, c);
            if (a && nx < 5) nx++;
            if (out_valid) begin
                if (!have) begin
                    hold = cur();
                    have = 1'b1;
                end else begin
                    total++;
                    if (cur() !== hold) begin bad++; $display("FAIL bp_stable got=%h want=%h", cur(), hold); end
                end
            end
        end
        total++;
        if (nx !== 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", nx); end
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            drive(nx < 6, fm[nx % 6], xs[nx % 6], 4'(nx), 1'b1, a, c);
            if (a) nx++;
        end
        total++;
        if (got.size() != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp_q[i] || got[i].tag !== 4'(i))
                begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_alternate();
        logic a, c;
        int   na, nc;
        fp_fmt_e f;
        got.delete();
        exp_q.delete();
        na = 0;
        nc = 0;
        for (int i = 0; i < 20; i++) begin
            f = (i % 2 == 1) ? FP16X2 : FP32;
            drive(1'b1, f, rx(f), 4'(i), 1'b1, a, c);
            na += int'(a);
            nc += int'(c);
        end
        total++;
        if (na !== 20) begin bad++; $display("FAIL alt_accepts got=%0d want=20", na); end
        total++;
        if (nc !== 18) begin bad++; $display("FAIL alt_throughput got=%0d want=18", nc); end
        for (int cyc = 0; cyc < 20 && got.size() < 20; cyc++) drive(1'b0, FP32, '0, '0, 1'b1, a, c);
        total++;
        if (got.size() != 20) begin bad++; $display("FAIL alt_count got=%0d want=20", got.size()); end
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp_q[i]) begin bad++; $display("FAIL alt_result%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic a, c;
        fp_fmt_e f;
        int   errs;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            f = rfmt();
            drive($urandom_range(0, 9) < 7, f, rx(f), 4'($urandom), $urandom_range(0, 9) < 6, a, c);
        end
        for (int cyc = 0; cyc < 20 && got.size() < exp_q.size(); cyc++) drive(1'b0, FP32, '0, '0, 1'b1, a, c);
        total++;
        if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp_q.size()); end
        errs = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                errs++;
                if (errs <= 5) $display("FAIL rand_result%0d got=%h want=%h", i, got[i], exp_q[i]);
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    task automatic test_reset_flush();
        logic a, c;
        int   lat;
        logic [27:0] x;
        got.delete();
        exp_q.delete();
        drive(1'b1, FP32, rx(FP32), 4'd1, 1'b1, a, c);
        drive(1'b1, FP16X2, rx(FP16X2), 4'd2, 1'b1, a, c);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_prefill got=%b want=1", out_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async got=%b want=0", out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        for (int cyc = 0; cyc < 6; cyc++) drive(1'b0, FP32, '0, '0, 1'b1, a, c);
        total++;
        if (got.size() != 0) begin bad++; $display("FAIL rst_discard got=%0d want=0", got.size()); end
        drive(1'b1, FP32, rx(FP32), 4'd3, 1'b1, a, c);
        drive(1'b1, FP16X2, rx(FP16X2), 4'd4, 1'b1, a, c);
        flush = 1'b1;
        drive(1'b1, FP32, 28'h0000100, 4'd5, 1'b0, a, c);
        flush = 1'b0;
        got.delete();
        exp_q.delete();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", out_valid); end
        x = rx(FP16X2);
        drive(1'b1, FP16X2, x, 4'd9, 1'b1, a, c);
        lat = 0;
        while (got.size() == 0 && lat < 10) begin
            drive(1'b0, FP32, '0, '0, 1'b1, a, c);
            lat++;
        end
        for (int cyc = 0; cyc < 4; cyc++) drive(1'b0, FP32, '0, '0, 1'b1, a, c);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL flush_latency got=%0d want=2", lat); end
        total++;
        if (got.size() != 1 || got[0] !== model(FP16X2, x, 4'd9)) begin
            bad++;
            $display("FAIL flush_result count=%0d got=%h want=%h", got.size(),
                     (got.size() > 0) ? got[0] : '0, model(FP16X2, x, 4'd9));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_alternate();
        test_random();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
